bcd_interval_counter: RTL and testbench

- Parametrised multi-digit BCD timebase counter; successor to the single-digit tenths counter.
- Divides clk by a programmable prescale to produce a step tick, then counts that tick across DIGITS cascaded BCD digits.
- Supports run/pause, up/down, synchronous clear, parallel load, and a configurable top-digit limit (e.g. 5 for a seconds-tens digit).
- Feeds the stopwatch display mux and cascades to further counters via wrap.

---
 rtl/bcd_interval_counter.sv | 117 +++++++++++
 tb/tb_bcd_interval_counter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_interval_counter.sv
// Multi-digit BCD timebase counter: a programmable prescaler produces a step
// tick, and each step advances (or retreats) a cascade of BCD digits whose
// most-significant digit is limited to TOP_MAX.
module bcd_interval_counter #(
    parameter int unsigned TICK_DIV = 5_000_000,
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TOP_MAX  = 9,
    parameter int unsigned DIV_W    = $clog2(TICK_DIV)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  clear,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick,
    output logic                  wrap
);

    localparam int unsigned CNT_W = 4 * DIGITS;
    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;

    logic [CNT_W-1:0] stepped_c;
    logic             roll_c;
    logic [CNT_W-1:0] clamped_c;

    // Largest legal value of digit idx: TOP_MAX for the top digit, 9 elsewhere.
    function automatic logic [3:0] digit_max(input int unsigned idx);
        return (idx == DIGITS - 1) ? 4'(TOP_MAX) : 4'd9;
    endfunction

    // Ripple the step through the digits; roll_c survives only if every digit rolled.
    always_comb begin
        stepped_c = count_q;
        roll_c    = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (roll_c) begin
                if (up) begin
                    if (count_q[4*i +: 4] >= digit_max(i)) begin
                        stepped_c[4*i +: 4] = 4'd0;
                    end else begin
                        stepped_c[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                        roll_c              = 1'b0;
                    end
                end else begin
                    if (count_q[4*i +: 4] == 4'd0) begin
                        stepped_c[4*i +: 4] = digit_max(i);
                    end else begin
                        stepped_c[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                        roll_c              = 1'b0;
                    end
                end
            end
        end
    end

    // Saturate each load digit into its legal range.
    always_comb begin
        clamped_c = load_val;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > digit_max(i)) begin
                clamped_c[4*i +: 4] = digit_max(i);
            end
        end
    end

    // Next state: clear beats load beats step; a step is lost if either is active.
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (clear) begin
            presc_d = '0;
            count_d = '0;
        end else if (load) begin
            presc_d = '0;
            count_d = clamped_c;
        end else if (run) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                count_d = stepped_c;
                tick_d  = 1'b1;
                wrap_d  = roll_c;
            end else begin
                presc_d = presc_q + DIV_W'(1);
            end
        end
    end

    // State and output registers with asynchronous zeroing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_bcd_interval_counter.sv
// Bench for bcd_interval_counter: directed scenarios followed by random
// stimulus, compared every cycle against an integer-valued reference model.
module tb_bcd_interval_counter;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned DIGITS   = 2;
    localparam int unsigned TOP_MAX  = 5;
    localparam int          MODULUS  = (TOP_MAX + 1) * 10;

    logic       clk;
    logic       reset;
    logic       run;
    logic       clear;
    logic       up;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tick;
    logic       wrap;

    int n_vec;
    int n_err;

    // Reference model: count held as a plain integer 0..MODULUS-1.
    int m_val;
    int m_ph;
    bit m_tick;
    bit m_wrap;

    bcd_interval_counter #(
        .TICK_DIV (TICK_DIV),
        .DIGITS   (DIGITS),
        .TOP_MAX  (TOP_MAX)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .clear    (clear),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tick     (tick),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic int clamp_load(input logic [7:0] lv);
        int hi;
        int lo;
        lo = int'(lv[3:0]);
        hi = int'(lv[7:4]);
        if (lo > 9) lo = 9;
        if (hi > int'(TOP_MAX)) hi = int'(TOP_MAX);
        return hi * 10 + lo;
    endfunction

    // Advance the model by one clock using the inputs the DUT sees at this edge.
    task automatic model_edge();
        m_tick = 1'b0;
        m_wrap = 1'b0;
        if (reset) begin
            m_val = 0;
            m_ph  = 0;
        end else if (clear) begin
            m_val = 0;
            m_ph  = 0;
        end else if (load) begin
            m_val = clamp_load(load_val);
            m_ph  = 0;
        end else if (run) begin
            if (m_ph == int'(TICK_DIV) - 1) begin
                m_ph   = 0;
                m_tick = 1'b1;
                if (up) begin
                    m_wrap = (m_val == MODULUS - 1);
                    m_val  = (m_val + 1) % MODULUS;
                end else begin
                    m_wrap = (m_val == 0);
                    m_val  = (m_val + MODULUS - 1) % MODULUS;
                end
            end else begin
                m_ph = m_ph + 1;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("count", 32'(count), 32'(to_bcd(m_val)));
        check_eq("tick",  32'(tick),  32'(m_tick));
        check_eq("wrap",  32'(wrap),  32'(m_wrap));
    endtask

    // One clock: wait for the edge, step the model, then compare just after.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Pulse reset between edges and confirm the outputs clear immediately.
    task automatic async_reset_pulse();
        #2;
        reset = 1'b1;
        #1;
        m_val  = 0;
        m_ph   = 0;
        m_tick = 1'b0;
        m_wrap = 1'b0;
        check_eq("async_rst_count", 32'(count), 32'h0);
        check_eq("async_rst_tick",  32'(tick),  32'h0);
        check_eq("async_rst_wrap",  32'(wrap),  32'h0);
        #1;
        reset = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        load_val = v;
        cycle();
        load = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        m_val    = 0;
        m_ph     = 0;
        m_tick   = 1'b0;
        m_wrap   = 1'b0;
        reset    = 1'b1;
        run      = 1'b0;
        clear    = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        load_val = 8'h00;

        // Reset state.
        cycles(2);
        check_eq("reset_count", 32'(count), 32'h0);

        // Free-running up count: first tick on the 4th edge, then every 4.
        reset = 1'b0;
        run   = 1'b1;
        cycles(3);
        check_eq("no_early_tick", 32'(tick), 32'h0);
        cycle();
        check_eq("first_tick", 32'(tick), 32'h1);
        check_eq("first_count", 32'(count), 32'h01);
        cycles(36);
        check_eq("count_10", 32'(count), 32'h10);

        // Full-range rollover 59 -> 00.
        do_load(8'h58);
        check_eq("load_58", 32'(count), 32'h58);
        cycles(4);
        check_eq("to_59", 32'(count), 32'h59);
        cycles(4);
        check_eq("rollover_count", 32'(count), 32'h00);
        check_eq("rollover_wrap",  32'(wrap),  32'h1);
        cycles(4);
        check_eq("post_wrap", 32'(wrap), 32'h0);

        // Down count with borrow and full-range rollunder.
        up = 1'b0;
        do_load(8'h10);
        cycles(4);
        check_eq("borrow_09", 32'(count), 32'h09);
        do_load(8'h00);
        cycles(4);
        check_eq("rollunder_count", 32'(count), 32'h59);
        check_eq("rollunder_wrap",  32'(wrap),  32'h1);
        up = 1'b1;

        // Pause keeps the partial interval.
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        cycles(2);
        run = 1'b0;
        cycles(10);
        check_eq("pause_count", 32'(count), 32'h00);
        run = 1'b1;
        cycle();
        check_eq("resume_no_tick", 32'(tick), 32'h0);
        cycle();
        check_eq("resume_tick", 32'(tick), 32'h1);

        // Clamped load and prescaler restart.
        cycles(2);
        do_load(8'hA7);
        check_eq("clamp_load", 32'(count), 32'h57);
        do_load(8'hFF);
        check_eq("clamp_both", 32'(count), 32'h59);
        cycles(3);
        check_eq("load_no_tick", 32'(tick), 32'h0);
        cycle();
        check_eq("load_tick", 32'(tick), 32'h1);

        // Clear coincident with a step cycle.
        do_load(8'h33);
        cycles(3);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        check_eq("clear_step_count", 32'(count), 32'h00);
        check_eq("clear_step_tick",  32'(tick),  32'h0);

        // Async reset mid-interval.
        do_load(8'h42);
        cycles(2);
        async_reset_pulse();
        cycles(4);

        // Random stimulus.
        for (int n = 0; n < 3000; n++) begin
            run      = ($urandom_range(0, 9) != 0);
            up       = 1'($urandom_range(0, 1));
            clear    = ($urandom_range(0, 99) == 0);
            load     = ($urandom_range(0, 39) == 0);
            load_val = 8'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                async_reset_pulse();
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
